// File: rtl/serial_adder_if.sv
// Request/result bundle for the bit-serial adder: a start request carrying the operands,
// and the busy/done status with the registered sum and carry-out.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a_in, b_in, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a_in, b_in, c_in,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a registered carry adds two WIDTH-bit
// operands LSB first, one bit per clock, then presents a registered sum/carry with a done pulse.
module serial_adder_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  serial_adder_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int                CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s, fa_c;
  logic             busy, done;

  serial_adder_fa u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // RUN spends WIDTH slice cycles plus one commit cycle (cnt == WIDTH); the commit lands
  // on the edge into DONE so sum/c_out are already valid while done is high.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          carry_d = bus.c_in;
          cnt_d   = '0;
          p_d     = '0;
        end
      end
      RUN: begin
        if (cnt_q != LAST) begin
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          p_d     = WIDTH'({fa_s, p_q} >> 1);
          carry_d = fa_c;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          sum_d   = p_q;
          c_out_d = carry_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: drivers push expected results computed with plain
// integer addition; per-instance monitors compare whenever done is presented.
module tb_serial_adder;
  localparam int W8 = 8;
  localparam int W1 = 1;

  typedef struct {
    logic [7:0] sum;
    logic       c_out;
    int         due;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  exp_t       q8[$];
  exp_t       q1[$];
  int         bf8 = 0, bt8 = -1;
  int         bf1 = 0, bt1 = -1;
  logic [7:0] last8   = '0;
  logic       last8_c = 1'b0;
  logic [0:0] last1   = '0;
  logic       last1_c = 1'b0;

  serial_adder_if #(.WIDTH(W8)) bus8 ();
  serial_adder_if #(.WIDTH(W1)) bus1 ();

  serial_adder #(.WIDTH(W8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  serial_adder #(.WIDTH(W1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor for the WIDTH=8 instance.
  always @(negedge clk) begin
    logic exp_done;
    exp_t e;
    if (!reset) begin
      exp_done = (q8.size() > 0) && (q8[0].due == cyc);
      check("done8", 32'(bus8.done), 32'(exp_done));
      check("busy8", 32'(bus8.busy), 32'(cyc >= bf8 && cyc <= bt8));
      if (bus8.done && q8.size() > 0) begin
        e = q8.pop_front();
        check("sum8", 32'(bus8.sum), 32'(e.sum));
        check("cout8", 32'(bus8.c_out), 32'(e.c_out));
        last8   = e.sum;
        last8_c = e.c_out;
      end else begin
        check("hold8_sum", 32'(bus8.sum), 32'(last8));
        check("hold8_cout", 32'(bus8.c_out), 32'(last8_c));
      end
    end
  end

  // Monitor for the WIDTH=1 instance.
  always @(negedge clk) begin
    logic exp_done;
    exp_t e;
    if (!reset) begin
      exp_done = (q1.size() > 0) && (q1[0].due == cyc);
      check("done1", 32'(bus1.done), 32'(exp_done));
      check("busy1", 32'(bus1.busy), 32'(cyc >= bf1 && cyc <= bt1));
      if (bus1.done && q1.size() > 0) begin
        e = q1.pop_front();
        check("sum1", 32'(bus1.sum), 32'(e.sum));
        check("cout1", 32'(bus1.c_out), 32'(e.c_out));
        last1   = e.sum[0:0];
        last1_c = e.c_out;
      end else begin
        check("hold1_sum", 32'(bus1.sum), 32'(last1));
        check("hold1_cout", 32'(bus1.c_out), 32'(last1_c));
      end
    end
  end

  function automatic exp_t model(input int width, input int a, input int b, input int c, input int due);
    exp_t e;
    int   total;
    total   = a + b + c;
    e.sum   = 8'(total % (1 << width));
    e.c_out = (total >> width) != 0;
    e.due   = due;
    return e;
  endfunction

  task automatic push8(input logic [7:0] a, input logic [7:0] b, input logic c);
    q8.push_back(model(W8, int'(a), int'(b), int'(c), cyc + W8 + 1));
    bf8 = cyc;
    bt8 = cyc + W8 + 1;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    while (cyc <= bt8) @(negedge clk);
    bus8.start = 1'b1;
    bus8.a_in  = a;
    bus8.b_in  = b;
    bus8.c_in  = c;
    @(posedge clk);
    #1;
    push8(a, b, c);
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a_in  = 8'($urandom);
    bus8.b_in  = 8'($urandom);
    bus8.c_in  = 1'($urandom);
  endtask

  task automatic issue1(input logic a, input logic b, input logic c);
    @(negedge clk);
    while (cyc <= bt1) @(negedge clk);
    bus1.start = 1'b1;
    bus1.a_in  = a;
    bus1.b_in  = b;
    bus1.c_in  = c;
    @(posedge clk);
    #1;
    q1.push_back(model(W1, int'(a), int'(b), int'(c), cyc + W1 + 1));
    bf1 = cyc;
    bt1 = cyc + W1 + 1;
    @(negedge clk);
    bus1.start = 1'b0;
    bus1.a_in  = ~a;
    bus1.b_in  = ~b;
    bus1.c_in  = ~c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    bus8.start = 1'b0; bus8.a_in = '0; bus8.b_in = '0; bus8.c_in = 1'b0;
    bus1.start = 1'b0; bus1.a_in = '0; bus1.b_in = '0; bus1.c_in = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_sum8", 32'(bus8.sum), 32'h0);
    check("rst_cout8", 32'(bus8.c_out), 32'h0);
    check("rst_busy8", 32'(bus8.busy), 32'h0);
    check("rst_done8", 32'(bus8.done), 32'h0);
    check("rst_busy1", 32'(bus1.busy), 32'h0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    // Idle with no start: monitors check busy/done/sum every cycle.
    repeat (20) @(negedge clk);
    check("idle_sum8", 32'(bus8.sum), 32'h0);
    check("idle_busy8", 32'(bus8.busy), 32'h0);

    issue8(8'hFF, 8'h01, 1'b0);
    issue8(8'hA5, 8'h5A, 1'b1);
    issue8(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 24; i++) issue8(8'($urandom), 8'($urandom), 1'($urandom));
    issue8(8'hFF, 8'hFF, 1'b1);
    issue8(8'h00, 8'h00, 1'b0);

    // Start held high: mid-run operand changes must be ignored, and the next
    // start is taken in the first IDLE cycle after done.
    @(negedge clk);
    while (cyc <= bt8) @(negedge clk);
    bus8.start = 1'b1; bus8.a_in = 8'h03; bus8.b_in = 8'h04; bus8.c_in = 1'b0;
    @(posedge clk);
    #1;
    acc = cyc;
    push8(8'h03, 8'h04, 1'b0);
    @(negedge clk);
    while (cyc < acc + W8 + 2) begin
      bus8.a_in = 8'($urandom);
      bus8.b_in = 8'($urandom);
      bus8.c_in = 1'($urandom);
      @(negedge clk);
    end
    bus8.a_in = 8'h90; bus8.b_in = 8'h80; bus8.c_in = 1'b0;
    @(posedge clk);
    #1;
    check("restart_edge", 32'(cyc), 32'(acc + W8 + 3));
    push8(8'h90, 8'h80, 1'b0);
    @(negedge clk);
    bus8.start = 1'b0;

    // Asynchronous reset after three bits of FF+FF: outputs clear at once, no done.
    issue8(8'hFF, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("midrst_sum8", 32'(bus8.sum), 32'h0);
    check("midrst_cout8", 32'(bus8.c_out), 32'h0);
    check("midrst_busy8", 32'(bus8.busy), 32'h0);
    check("midrst_done8", 32'(bus8.done), 32'h0);
    q8.delete(); q1.delete();
    bf8 = 0; bt8 = -1; bf1 = 0; bt1 = -1;
    last8 = '0; last8_c = 1'b0; last1 = '0; last1_c = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    repeat (4) @(negedge clk);
    issue8(8'h01, 8'h01, 1'b0);

    // WIDTH=1 instance walks the full-adder truth table.
    for (int k = 0; k < 8; k++) issue1(1'(k), 1'(k >> 1), 1'(k >> 2));

    @(negedge clk);
    while (cyc <= bt8 + 2 || cyc <= bt1 + 2) @(negedge clk);
    check("drain8", 32'(q8.size()), 32'h0);
    check("drain1", 32'(q1.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
